// File: rtl/aes_axil_regs.sv
// AXI-Lite register block for an AES CTR core: holds key/IV, CTRL/STATUS/ID registers,
// and issues a one-cycle start pulse. The write channel is sequenced by a small FSM.
module aes_axil_regs #(
  parameter logic [31:0] VERSION = 32'h4145_5301
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   s_axil_awaddr,
  input  logic         s_axil_awvalid,
  output logic         s_axil_awready,
  input  logic [31:0]  s_axil_wdata,
  input  logic [3:0]   s_axil_wstrb,
  input  logic         s_axil_wvalid,
  output logic         s_axil_wready,
  output logic [1:0]   s_axil_bresp,
  output logic         s_axil_bvalid,
  input  logic         s_axil_bready,
  input  logic [5:0]   s_axil_araddr,
  input  logic         s_axil_arvalid,
  output logic         s_axil_arready,
  output logic [31:0]  s_axil_rdata,
  output logic [1:0]   s_axil_rresp,
  output logic         s_axil_rvalid,
  input  logic         s_axil_rready,
  output logic [127:0] aes_key,
  output logic [127:0] aes_iv,
  output logic         key_iv_valid,
  output logic         start,
  input  logic         core_busy,
  input  logic         core_done,
  output logic [1:0]   wr_state_dbg
);

  // Valid/ready: a beat transfers on a rising clk edge where both valid and ready are high;
  // a source holds valid and its payload steady until that edge.
  typedef enum logic [1:0] {WR_IDLE, WR_PARTIAL, WR_COMMIT, WR_RESP} wr_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  wr_state_e      wr_state_q, wr_state_d;
  logic           aw_held_q, aw_held_d;
  logic [3:0]     aw_word_q, aw_word_d;
  logic           w_held_q, w_held_d;
  logic [31:0]    w_data_q, w_data_d;
  logic [3:0]     w_strb_q, w_strb_d;
  logic           bvalid_q, bvalid_d;
  logic [1:0]     bresp_q, bresp_d;
  logic           kiv_q, kiv_d;
  logic           done_q, done_d;
  logic           start_err_q, start_err_d;
  logic           start_q, start_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   iv_q, iv_d;
  logic           rvalid_q, rvalid_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [1:0]     rresp_q, rresp_d;

  logic           aw_hs, w_hs, ar_hs;
  logic           done_clr, err_clr, err_set;
  logic [31:0]    wmask;
  logic           unused_addr_bits;

  assign unused_addr_bits = &{1'b0, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  // Ready outputs are forced low while rst is held so nothing is accepted during reset.
  assign s_axil_awready = !rst && !aw_held_q && !bvalid_q;
  assign s_axil_wready  = !rst && !w_held_q && !bvalid_q;
  assign s_axil_arready = !rst && !rvalid_q;

  assign aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_hs  = s_axil_wvalid && s_axil_wready;
  assign ar_hs = s_axil_arvalid && s_axil_arready;

  assign wmask = {{8{w_strb_q[3]}}, {8{w_strb_q[2]}}, {8{w_strb_q[1]}}, {8{w_strb_q[0]}}};

  always_comb begin
    wr_state_d  = wr_state_q;
    aw_held_d   = aw_held_q;
    aw_word_d   = aw_word_q;
    w_held_d    = w_held_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    kiv_d       = kiv_q;
    key_d       = key_q;
    iv_d        = iv_q;
    start_d     = 1'b0;
    done_clr    = 1'b0;
    err_clr     = 1'b0;
    err_set     = 1'b0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_word_d = s_axil_awaddr[5:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s_axil_wdata;
      w_strb_d = s_axil_wstrb;
    end

    case (wr_state_q)
      WR_IDLE, WR_PARTIAL: begin
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          wr_state_d = WR_COMMIT;
        end else if (aw_held_q || aw_hs || w_held_q || w_hs) begin
          wr_state_d = WR_PARTIAL;
        end
      end
      WR_COMMIT: begin
        wr_state_d = WR_RESP;
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        bvalid_d   = 1'b1;
        bresp_d    = RESP_OKAY;
        case (aw_word_q)
          4'h0: begin
            // KEY_IV_VALID lands first so START sees the value written alongside it.
            if (w_strb_q[1]) kiv_d = w_data_q[8];
            if (w_strb_q[0] && w_data_q[0]) begin
              if (kiv_d && !core_busy) start_d = 1'b1;
              else                     err_set = 1'b1;
            end
          end
          4'h1: begin
            if (w_strb_q[0]) begin
              done_clr = w_data_q[1];
              err_clr  = w_data_q[2];
            end
          end
          4'h4, 4'h5, 4'h6, 4'h7: begin
            key_d[{aw_word_q[1:0], 5'd0} +: 32] =
              (w_data_q & wmask) | (key_q[{aw_word_q[1:0], 5'd0} +: 32] & ~wmask);
            kiv_d = 1'b0;
          end
          4'h8, 4'h9, 4'hA, 4'hB: begin
            iv_d[{aw_word_q[1:0], 5'd0} +: 32] =
              (w_data_q & wmask) | (iv_q[{aw_word_q[1:0], 5'd0} +: 32] & ~wmask);
            kiv_d = 1'b0;
          end
          default: bresp_d = RESP_SLVERR;
        endcase
      end
      WR_RESP: begin
        if (s_axil_bready) begin
          wr_state_d = WR_IDLE;
          bvalid_d   = 1'b0;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase

    // A core_done in the same cycle as a DONE clear wins.
    done_d      = (done_q && !done_clr) || core_done;
    start_err_d = (start_err_q && !err_clr) || err_set;
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s_axil_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      case (s_axil_araddr[5:2])
        4'h0:                   rdata_d = {23'd0, kiv_q, 8'd0};
        4'h1:                   rdata_d = {29'd0, start_err_q, done_q, core_busy};
        4'h2:                   rdata_d = VERSION;
        4'h4, 4'h5, 4'h6, 4'h7: rdata_d = 32'd0;
        4'h8, 4'h9, 4'hA, 4'hB: rdata_d = iv_q[{s_axil_araddr[3:2], 5'd0} +: 32];
        default: begin
          rdata_d = 32'd0;
          rresp_d = RESP_SLVERR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q  <= WR_IDLE;
      aw_held_q   <= 1'b0;
      aw_word_q   <= 4'd0;
      w_held_q    <= 1'b0;
      w_data_q    <= 32'd0;
      w_strb_q    <= 4'd0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      kiv_q       <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      start_q     <= 1'b0;
      key_q       <= 128'd0;
      iv_q        <= 128'd0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'd0;
      rresp_q     <= 2'b00;
    end else begin
      wr_state_q  <= wr_state_d;
      aw_held_q   <= aw_held_d;
      aw_word_q   <= aw_word_d;
      w_held_q    <= w_held_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      kiv_q       <= kiv_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
      start_q     <= start_d;
      key_q       <= key_d;
      iv_q        <= iv_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
    end
  end

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;
  assign aes_key       = key_q;
  assign aes_iv        = iv_q;
  assign key_iv_valid  = kiv_q;
  assign start         = start_q;
  assign wr_state_dbg  = wr_state_q;

endmodule

// File: tb/tb_aes_axil_regs.sv
// Self-checking bench for aes_axil_regs: directed scenarios plus randomized AXI-Lite
// traffic, checked against a register-map model kept in the bench.
module tb_aes_axil_regs;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [5:0]   s_axil_awaddr = '0;
  logic         s_axil_awvalid = 1'b0;
  logic         s_axil_awready;
  logic [31:0]  s_axil_wdata = '0;
  logic [3:0]   s_axil_wstrb = '0;
  logic         s_axil_wvalid = 1'b0;
  logic         s_axil_wready;
  logic [1:0]   s_axil_bresp;
  logic         s_axil_bvalid;
  logic         s_axil_bready = 1'b0;
  logic [5:0]   s_axil_araddr = '0;
  logic         s_axil_arvalid = 1'b0;
  logic         s_axil_arready;
  logic [31:0]  s_axil_rdata;
  logic [1:0]   s_axil_rresp;
  logic         s_axil_rvalid;
  logic         s_axil_rready = 1'b0;
  logic [127:0] aes_key;
  logic [127:0] aes_iv;
  logic         key_iv_valid;
  logic         start;
  logic         core_busy = 1'b0;
  logic         core_done = 1'b0;
  logic [1:0]   wr_state_dbg;

  always #5 clk = ~clk;

  aes_axil_regs dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
    .s_axil_rready(s_axil_rready),
    .aes_key(aes_key), .aes_iv(aes_iv), .key_iv_valid(key_iv_valid), .start(start),
    .core_busy(core_busy), .core_done(core_done), .wr_state_dbg(wr_state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;
  int start_seen = 0;
  int exp_starts = 0;

  // Reference register map
  logic [31:0] m_key [4];
  logic [31:0] m_iv  [4];
  bit          m_kiv, m_done, m_err;
  logic [33:0] exp_q [$];

  always @(negedge clk) if (start === 1'b1) start_seen++;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_key[i] = '0;
      m_iv[i]  = '0;
    end
    m_kiv = 0; m_done = 0; m_err = 0;
  endfunction

  function automatic logic [127:0] m_key_vec();
    return {m_key[3], m_key[2], m_key[1], m_key[0]};
  endfunction

  function automatic logic [127:0] m_iv_vec();
    return {m_iv[3], m_iv[2], m_iv[1], m_iv[0]};
  endfunction

  function automatic void model_write(input logic [5:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb, output logic [1:0] resp,
                                      output bit pulse);
    int w;
    w = int'(addr) / 4;
    pulse = 0;
    resp  = 2'b00;
    if (w == 0) begin
      if (strb[1]) m_kiv = data[8];
      if (strb[0] && data[0]) begin
        if (m_kiv && !core_busy) pulse = 1;
        else                     m_err = 1;
      end
    end else if (w == 1) begin
      if (strb[0] && data[1]) m_done = 0;
      if (strb[0] && data[2]) m_err  = 0;
    end else if (w >= 4 && w <= 11) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) begin
          if (w < 8) m_key[w-4][8*b +: 8] = data[8*b +: 8];
          else       m_iv[w-8][8*b +: 8]  = data[8*b +: 8];
        end
      end
      m_kiv = 0;
    end else begin
      resp = 2'b10;
    end
    if (pulse) exp_starts++;
  endfunction

  function automatic logic [33:0] model_read(input logic [5:0] addr);
    int w;
    w = int'(addr) / 4;
    case (w)
      0:             return {2'b00, 32'(m_kiv) << 8};
      1:             return {2'b00, 29'd0, m_err, m_done, core_busy};
      2:             return {2'b00, 32'h4145_5301};
      4, 5, 6, 7:    return {2'b00, 32'd0};
      8, 9, 10, 11:  return {2'b00, m_iv[w-8]};
      default:       return {2'b10, 32'd0};
    endcase
  endfunction

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, input bit done_pulse);
    logic [1:0] exp_resp;
    bit exp_pulse, aw_ok, w_ok, aw_hs, w_hs;
    int cyc, lat;
    model_write(addr, data, strb, exp_resp, exp_pulse);
    if (done_pulse) m_done = 1;
    @(posedge clk); #1;
    aw_ok = 0; w_ok = 0; cyc = 0;
    while (!(aw_ok && w_ok) && cyc < 40) begin
      s_axil_awvalid = !aw_ok && (cyc >= aw_dly);
      s_axil_awaddr  = addr;
      s_axil_wvalid  = !w_ok && (cyc >= w_dly);
      s_axil_wdata   = data;
      s_axil_wstrb   = strb;
      @(negedge clk);
      aw_hs = s_axil_awvalid && s_axil_awready;
      w_hs  = s_axil_wvalid && s_axil_wready;
      @(posedge clk); #1;
      aw_ok = aw_ok || aw_hs;
      w_ok  = w_ok || w_hs;
      cyc++;
    end
    s_axil_awvalid = 0;
    s_axil_wvalid  = 0;
    check_eq("wr_accept", {aw_ok, w_ok}, 2'b11);
    if (done_pulse) core_done = 1;
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (s_axil_bvalid || lat > 10) break;
      lat++;
      @(posedge clk); #1;
      core_done = 0;
    end
    core_done = 0;
    check_eq("wr_b_latency", lat, 1);
    check_eq("wr_bresp", s_axil_bresp, exp_resp);
    check_eq("wr_start", start, exp_pulse);
    check_eq("wr_key", aes_key, m_key_vec());
    check_eq("wr_iv", aes_iv, m_iv_vec());
    check_eq("wr_kiv", key_iv_valid, m_kiv);
    for (int i = 0; i < b_dly; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("wr_b_hold", {s_axil_bvalid, s_axil_awready, s_axil_wready, s_axil_bresp},
               {3'b100, exp_resp});
    end
    @(posedge clk); #1;
    s_axil_bready = 1;
    @(posedge clk); #1;
    s_axil_bready = 0;
    @(negedge clk);
    check_eq("wr_b_done", {s_axil_bvalid, s_axil_awready, s_axil_wready}, 3'b011);
  endtask

  task automatic axi_read(input logic [5:0] addr, input int r_dly);
    logic [33:0] exp;
    bit hs;
    int cyc;
    exp_q.push_back(model_read(addr));
    @(posedge clk); #1;
    s_axil_arvalid = 1;
    s_axil_araddr  = addr;
    hs = 0; cyc = 0;
    while (!hs && cyc < 20) begin
      @(negedge clk);
      hs = s_axil_arready;
      @(posedge clk); #1;
      cyc++;
    end
    s_axil_arvalid = 0;
    @(negedge clk);
    exp = exp_q.pop_front();
    check_eq($sformatf("rd_%02h", addr), {s_axil_rvalid, s_axil_rresp, s_axil_rdata}, {1'b1, exp});
    for (int i = 0; i < r_dly; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("rd_hold", {s_axil_rvalid, s_axil_arready, s_axil_rresp, s_axil_rdata},
               {2'b10, exp});
    end
    @(posedge clk); #1;
    s_axil_rready = 1;
    @(posedge clk); #1;
    s_axil_rready = 0;
    @(negedge clk);
    check_eq("rd_done", {s_axil_rvalid, s_axil_arready}, 2'b01);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    core_done = 1;
    m_done = 1;
    @(posedge clk); #1;
    core_done = 0;
  endtask

  initial begin
    logic [127:0] key_vec;
    logic [127:0] iv_vec;
    logic [5:0]   ra;
    int           op;

    key_vec = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    iv_vec  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    model_reset();

    // Clock/reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready_valid", {s_axil_awready, s_axil_wready, s_axil_arready,
                                 s_axil_bvalid, s_axil_rvalid, start}, 6'd0);
    check_eq("rst_outputs", {aes_key, aes_iv, key_iv_valid, s_axil_bresp, s_axil_rresp, s_axil_rdata},
             '0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check_eq("post_rst_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);

    // Known-answer key/IV load then START
    for (int n = 3; n >= 0; n--)
      axi_write(6'h10 + 6'(4*n), key_vec[32*n +: 32], 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), 0, 0);
    for (int n = 3; n >= 0; n--)
      axi_write(6'h20 + 6'(4*n), iv_vec[32*n +: 32], 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), 0, 0);
    axi_write(6'h00, 32'h101, 4'hF, 0, 0, 0, 0);
    check_eq("kat_key", aes_key, key_vec);
    check_eq("kat_iv", aes_iv, iv_vec);
    check_eq("kat_starts", start_seen, 1);
    axi_read(6'h00, 1);

    // ID / KEY / unmapped accesses
    axi_read(6'h08, 0);
    axi_read(6'h10, 2);
    axi_read(6'h30, 0);
    axi_write(6'h30, 32'hdead_beef, 4'hF, 0, 0, 0, 0);
    axi_write(6'h08, 32'h1234_5678, 4'hF, 1, 0, 0, 0);
    axi_read(6'h2C, 0);

    // IV write drops KEY_IV_VALID; W leads AW with a slow bready
    axi_write(6'h28, 32'haabb_ccdd, 4'b0101, 0, 0, 0, 0);
    axi_write(6'h24, 32'h1122_3344, 4'hF, 3, 0, 4, 0);
    axi_read(6'h24, 0);

    // START without KEY_IV_VALID, then W1C of START_ERR
    axi_write(6'h00, 32'h001, 4'hF, 0, 0, 0, 0);
    axi_read(6'h04, 0);
    axi_write(6'h04, 32'h4, 4'hF, 0, 0, 0, 0);
    axi_read(6'h04, 0);

    // START while core busy
    axi_write(6'h00, 32'h100, 4'hF, 0, 0, 0, 0);
    core_busy = 1;
    axi_write(6'h00, 32'h101, 4'hF, 0, 1, 0, 0);
    axi_read(6'h04, 0);
    core_busy = 0;
    axi_write(6'h04, 32'h4, 4'h1, 0, 0, 0, 0);

    // DONE set racing its own W1C
    pulse_done();
    axi_read(6'h04, 0);
    axi_write(6'h04, 32'h2, 4'h1, 0, 0, 1, 1);
    axi_read(6'h04, 0);
    axi_write(6'h04, 32'h2, 4'h1, 0, 0, 0, 0);
    axi_read(6'h04, 0);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      core_busy = ($urandom_range(0, 3) == 0);
      op = $urandom_range(0, 9);
      ra = 6'($urandom_range(0, 15) * 4);
      if (op < 6) begin
        axi_write(ra, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2), ($urandom_range(0, 4) == 0));
      end else if (op < 9) begin
        axi_read(ra, $urandom_range(0, 2));
      end else begin
        pulse_done();
      end
    end
    core_busy = 0;

    // Reset during an open write transaction
    @(posedge clk); #1;
    s_axil_awvalid = 1;
    s_axil_awaddr  = 6'h14;
    @(posedge clk); #1;
    s_axil_awvalid = 0;
    rst = 1;
    s_axil_wvalid = 1;
    s_axil_wdata  = 32'hffff_ffff;
    s_axil_wstrb  = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("midrst_hs", {s_axil_awready, s_axil_wready, s_axil_arready,
                           s_axil_bvalid, s_axil_rvalid, start}, 6'd0);
    check_eq("midrst_outputs", {aes_key, aes_iv, key_iv_valid, s_axil_bresp, s_axil_rresp,
                                s_axil_rdata}, '0);
    s_axil_wvalid = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    @(negedge clk);
    check_eq("midrst_release_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("midrst_no_bvalid", {s_axil_bvalid, aes_key}, '0);
    end
    axi_write(6'h20, 32'h0bad_cafe, 4'hF, 0, 2, 0, 0);
    axi_read(6'h20, 0);
    axi_read(6'h04, 0);

    @(posedge clk);
    @(negedge clk);
    check_eq("start_total", start_seen, exp_starts);
    check_eq("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
